// File: rtl/regset_fifo_ctrl.sv
// regset_fifo_ctrl: sequences push/pop streams into single-port regset accesses,
// using the regset as FIFO storage plus a one-entry head register.
module regset_fifo_ctrl #(
    parameter int DW    = 4,
    parameter int AW    = 3,
    parameter int DEPTH = 2**AW
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Push_valid,
    output logic          Push_ready,
    input  logic [DW-1:0] Push_data,
    output logic          Pop_valid,
    input  logic          Pop_ready,
    output logic [DW-1:0] Pop_data,
    output logic [AW:0]   Count,
    output logic          Full,
    output logic          Empty,
    output logic          Rs_RW,
    output logic [AW-1:0] Rs_Address,
    output logic [DW-1:0] Rs_Data_in,
    input  logic [DW-1:0] Rs_Data_out
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   scnt;
    logic          out_v, rd_sel, wr_sel;

    // Head refill reads win the port; pushes only get idle cycles.
    always_comb begin
        rd_sel     = (scnt != '0) && (!out_v || Pop_ready);
        Push_ready = Rst_n && !rd_sel && (scnt < FULL_CNT);
        wr_sel     = Push_valid && Push_ready;
        Rs_RW      = !wr_sel;
        Rs_Address = wr_sel ? wr_ptr : rd_ptr;
        Rs_Data_in = wr_sel ? Push_data : '0;
        Pop_valid  = out_v;
        Count      = scnt + {{AW{1'b0}}, out_v};
        Full       = scnt == FULL_CNT;
        Empty      = Count == '0;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            scnt     <= '0;
            out_v    <= 1'b0;
            Pop_data <= '0;
        end else begin
            if (rd_sel) begin
                Pop_data <= Rs_Data_out;
                out_v    <= 1'b1;
                rd_ptr   <= rd_ptr + AW'(1);
            end else if (out_v && Pop_ready) begin
                out_v <= 1'b0;
            end
            if (wr_sel)
                wr_ptr <= wr_ptr + AW'(1);
            scnt <= rd_sel ? scnt - (AW+1)'(1) : wr_sel ? scnt + (AW+1)'(1) : scnt;
        end
    end
endmodule

// File: tb/tb_regset_fifo_ctrl.sv
// tb_regset_fifo_ctrl: directed checks of the regset FIFO sequencer against an
// 8x4 regset model and hand-computed expectations.
module tb_regset_fifo_ctrl;
    logic       Clk = 1'b0, Rst_n = 1'b0;
    logic       Push_valid = 1'b0, Push_ready, Pop_valid, Pop_ready = 1'b0;
    logic [3:0] Push_data = '0, Pop_data, Rs_Data_in, Rs_Data_out;
    logic [3:0] Count;
    logic [2:0] Rs_Address;
    logic       Full, Empty, Rs_RW;
    logic [3:0] mem [8];
    int         n_checks = 0, n_err = 0;

    regset_fifo_ctrl dut (
        .Clk(Clk), .Rst_n(Rst_n), .Push_valid(Push_valid), .Push_ready(Push_ready),
        .Push_data(Push_data), .Pop_valid(Pop_valid), .Pop_ready(Pop_ready),
        .Pop_data(Pop_data), .Count(Count), .Full(Full), .Empty(Empty),
        .Rs_RW(Rs_RW), .Rs_Address(Rs_Address), .Rs_Data_in(Rs_Data_in),
        .Rs_Data_out(Rs_Data_out)
    );

    always #5 Clk = ~Clk;

    always_ff @(posedge Clk)
        if (!Rs_RW) mem[Rs_Address] <= Rs_Data_in;
    assign Rs_Data_out = mem[Rs_Address];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] d);
        int n = 0;
        @(negedge Clk);
        Push_valid = 1'b1;
        Push_data  = d;
        #1;
        while (!Push_ready && n < 20) begin
            @(negedge Clk);
            #1;
            n++;
        end
        check("push_timeout", (n < 20) ? 1 : 0, 1);
        @(posedge Clk);
        #1;
        Push_valid = 1'b0;
    endtask

    task automatic async_reset();
        @(posedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        check("rst_pop_valid", Pop_valid, 0);
        check("rst_count", Count, 0);
        check("rst_empty", Empty, 1);
        check("rst_rw", Rs_RW, 1);
        check("rst_addr", Rs_Address, 0);
        check("rst_push_ready", Push_ready, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    logic [3:0] vals [9] = '{5, 15, 11, 8, 9, 4, 12, 7, 3};
    logic [3:0] q [$];

    initial begin
        int idx, got, cyc, n;
        logic [2:0] prev_w, prev_r;
        logic wflag, rflag;
        logic [4:0] exp;
        #12;
        check("init_pop_valid", Pop_valid, 0);
        check("init_pop_data", Pop_data, 0);
        check("init_count", Count, 0);
        check("init_full", Full, 0);
        check("init_empty", Empty, 1);
        check("init_push_ready", Push_ready, 0);
        check("init_rw", Rs_RW, 1);
        check("init_addr", Rs_Address, 0);
        check("init_din", Rs_Data_in, 0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Fill with the consumer stalled
        idx = 0;
        for (cyc = 0; cyc < 40 && idx < 9; cyc++) begin
            @(negedge Clk);
            Push_valid = 1'b1;
            Push_data  = vals[idx];
            #1;
            if (cyc < 3) check("fill_push_ready", Push_ready, (cyc != 1) ? 1 : 0);
            if (Push_ready) begin
                check("fill_rw", Rs_RW, 0);
                check("fill_addr", Rs_Address, idx % 8);
                check("fill_din", Rs_Data_in, vals[idx]);
                idx++;
            end
            @(posedge Clk);
        end
        check("fill_done", idx, 9);
        @(negedge Clk);
        Push_data = 4'd1;
        #1;
        check("full_count", Count, 9);
        check("full_flag", Full, 1);
        check("full_push_ready", Push_ready, 0);
        check("full_pop_data", Pop_data, 5);
        check("full_pop_valid", Pop_valid, 1);
        @(negedge Clk);
        Push_valid = 1'b0;
        #1;
        check("full_ignored", Count, 9);

        // Drain
        for (int k = 0; k < 9; k++) begin
            @(negedge Clk);
            Pop_ready = 1'b1;
            #1;
            check("drain_valid", Pop_valid, 1);
            check("drain_data", Pop_data, vals[k]);
        end
        @(negedge Clk);
        #1;
        check("drain_empty", Empty, 1);
        check("drain_count", Count, 0);
        check("drain_pop_valid", Pop_valid, 0);

        // Streaming across pointer wrap
        idx = 0; got = 0; prev_w = 0; prev_r = 0; wflag = 0; rflag = 0;
        for (int c = 0; c < 200 && got < 20; c++) begin
            @(negedge Clk);
            Push_valid = idx < 20;
            Push_data  = 4'(idx % 16);
            #1;
            if (!Rs_RW) begin
                if (prev_w == 3'd7 && Rs_Address == 3'd0) wflag = 1;
                prev_w = Rs_Address;
            end else begin
                if (prev_r == 3'd7 && Rs_Address == 3'd0) rflag = 1;
                prev_r = Rs_Address;
            end
            if (Push_valid && Push_ready) begin
                q.push_back(Push_data);
                idx++;
            end
            if (Pop_valid && Pop_ready) begin
                exp = (q.size() > 0) ? {1'b0, q.pop_front()} : 5'h1f;
                check("wrap_data", Pop_data, exp);
                got++;
            end
        end
        Push_valid = 1'b0;
        check("wrap_got", got, 20);
        check("wrap_left", q.size(), 0);
        check("wrap_wr_ptr", wflag, 1);
        check("wrap_rd_ptr", rflag, 1);
        @(negedge Clk);
        #1;
        check("wrap_empty", Empty, 1);
        Pop_ready = 1'b0;

        // Read/write conflict: Scnt=2, OutV=1
        push(4'd1); push(4'd2); push(4'd3);
        @(negedge Clk);
        Pop_ready  = 1'b1;
        Push_valid = 1'b1;
        Push_data  = 4'd6;
        #1;
        check("conf_count0", Count, 3);
        check("conf_rw_read", Rs_RW, 1);
        check("conf_push_ready0", Push_ready, 0);
        @(negedge Clk);
        Pop_ready = 1'b0;
        #1;
        check("conf_rw_write", Rs_RW, 0);
        check("conf_din", Rs_Data_in, 6);
        check("conf_push_ready1", Push_ready, 1);
        @(posedge Clk);
        #1;
        Push_valid = 1'b0;
        @(negedge Clk);
        #1;
        check("conf_count1", Count, 3);
        check("conf_pop_data", Pop_data, 2);

        // Async reset with Count=3
        async_reset();

        // Reset mid-operation with Count=4, stale data never emitted
        push(4'd1); push(4'd2); push(4'd3); push(4'd4);
        @(negedge Clk);
        #1;
        check("pre_rst_count", Count, 4);
        async_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk);
            #1;
            check("stale_pop_valid", Pop_valid, 0);
        end
        push(4'd10);
        n = 0;
        while (!Pop_valid && n < 10) begin
            @(negedge Clk);
            #1;
            n++;
        end
        check("post_rst_valid", Pop_valid, 1);
        check("post_rst_data", Pop_data, 10);
        check("post_rst_count", Count, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
